// File: rtl/lcd_pkg.sv
// Shared types, 50 MHz timing defaults and HD44780 command codes for the LCD bus arbiter.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POWER_ON,
        ST_IDLE,
        ST_SETUP,
        ST_ENABLE,
        ST_EXEC
    } state_t;

    localparam int unsigned T_PWR_DEF        = 1000000;
    localparam int unsigned T_SETUP_DEF      = 2000;
    localparam int unsigned T_EN_DEF         = 50000;
    localparam int unsigned T_EXEC_SHORT_DEF = 2000;
    localparam int unsigned T_EXEC_LONG_DEF  = 100000;
    localparam int unsigned T_LOCK_TO_DEF    = 5000000;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    // Clear and return-home (bit 0 is don't-care on home) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable 32-bit down-counter; expire is high while the count sits at zero.
module lcd_phase_timer #(
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic        expire
);

    logic [31:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (count != 32'd0) begin
            count <= count - 32'd1;
        end
    end

    assign expire = (count == 32'd0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-writer HD44780 bus arbiter owning all LCD timing.
// Optional lock watchdog is compiled in with LCD_ARB_WATCHDOG_EN.
//
// state    | meaning
// POWER_ON | LCD power-up wait, no grants
// IDLE     | arbitrate between A and B
// SETUP    | rs/data settle before enable
// ENABLE   | enable pulse high
// EXEC     | wait for the LCD to execute the byte
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWR        = T_PWR_DEF,
    parameter int unsigned T_SETUP      = T_SETUP_DEF,
    parameter int unsigned T_EN         = T_EN_DEF,
    parameter int unsigned T_EXEC_SHORT = T_EXEC_SHORT_DEF,
    parameter int unsigned T_EXEC_LONG  = T_EXEC_LONG_DEF,
    parameter int unsigned T_LOCK_TO    = T_LOCK_TO_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       a_valid,
    input  logic       a_rs,
    input  logic [7:0] a_data,
    input  logic       a_lock,
    output logic       a_ready,
    output logic       a_done,
    input  logic       b_valid,
    input  logic       b_rs,
    input  logic [7:0] b_data,
    input  logic       b_lock,
    output logic       b_ready,
    output logic       b_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic       lcd_rw,
    output logic       lcd_on,
    output logic       lcd_blon,
    output logic       busy,
    output logic       owner,
    output logic       lock_err
);

    state_t      state, state_next;
    logic        timer_load, timer_expire;
    logic [31:0] timer_value;
    logic        lock, last_b;
    logic        elig_a, elig_b, grant_a, grant_b, grant, exec_done, wd_hit;

    lcd_phase_timer #(.RESET_VALUE(32'(T_PWR - 1))) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .expire     (timer_expire)
    );

    // A held lock narrows eligibility to the owner; otherwise ties go to the side not granted last.
    assign elig_a  = a_valid && (!lock || !owner);
    assign elig_b  = b_valid && (!lock || owner);
    assign grant_a = (state == ST_IDLE) && elig_a && (!elig_b || last_b);
    assign grant_b = (state == ST_IDLE) && elig_b && (!elig_a || !last_b);
    assign grant   = grant_a || grant_b;

    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_value = 32'd0;
        case (state)
            ST_POWER_ON: if (timer_expire) state_next = ST_IDLE;
            ST_IDLE: if (grant) begin
                state_next  = ST_SETUP;
                timer_load  = 1'b1;
                timer_value = 32'(T_SETUP - 1);
            end
            ST_SETUP: if (timer_expire) begin
                state_next  = ST_ENABLE;
                timer_load  = 1'b1;
                timer_value = 32'(T_EN - 1);
            end
            ST_ENABLE: if (timer_expire) begin
                state_next  = ST_EXEC;
                timer_load  = 1'b1;
                timer_value = is_long_cmd(lcd_rs, lcd_data) ? 32'(T_EXEC_LONG - 1)
                                                            : 32'(T_EXEC_SHORT - 1);
            end
            ST_EXEC: if (timer_expire) state_next = ST_IDLE;
            default: state_next = ST_POWER_ON;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_POWER_ON;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            owner    <= 1'b0;
            last_b   <= 1'b1;
            lock     <= 1'b0;
        end else if (grant_b) begin
            lcd_rs   <= b_rs;
            lcd_data <= b_data;
            owner    <= 1'b1;
            last_b   <= 1'b1;
            lock     <= b_lock;
        end else if (grant_a) begin
            lcd_rs   <= a_rs;
            lcd_data <= a_data;
            owner    <= 1'b0;
            last_b   <= 1'b0;
            lock     <= a_lock;
        end else if (wd_hit) begin
            lock     <= 1'b0;
        end
    end

`ifdef LCD_ARB_WATCHDOG_EN
    logic [31:0] wd_cnt;
    logic        wd_tick;

    // Only idle cycles with the lock owner silent count toward the timeout.
    assign wd_tick = (state == ST_IDLE) && lock && !(owner ? b_valid : a_valid);
    assign wd_hit  = wd_tick && (wd_cnt == 32'(T_LOCK_TO - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              wd_cnt <= 32'd0;
        else if (grant || wd_hit)  wd_cnt <= 32'd0;
        else if (wd_tick)          wd_cnt <= wd_cnt + 32'd1;
    end

    assign lock_err = wd_hit;
`else
    assign wd_hit   = 1'b0;
    assign lock_err = 1'b0;
`endif

    assign exec_done = (state == ST_EXEC) && timer_expire;
    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign a_done    = exec_done && !owner;
    assign b_done    = exec_done && owner;
    assign lcd_en    = (state == ST_ENABLE);
    assign lcd_rw    = 1'b0;
    assign lcd_on    = 1'b1;
    assign lcd_blon  = 1'b1;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench: directed timing scenarios plus randomized traffic against a cycle-time model.
module tb_lcd_bus_arbiter;
    import lcd_pkg::*;

    localparam int TP = 10, TS = 2, TE = 3, TXS = 4, TXL = 8, TLO = 20;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic       lock;
    } req_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       a_valid = 0, a_rs = 0, a_lock = 0, b_valid = 0, b_rs = 0, b_lock = 0;
    logic [7:0] a_data = 0, b_data = 0;
    logic       a_ready, a_done, b_ready, b_done;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_en, lcd_rw, lcd_on, lcd_blon, busy, owner, lock_err;

    lcd_bus_arbiter #(
        .T_PWR(TP), .T_SETUP(TS), .T_EN(TE),
        .T_EXEC_SHORT(TXS), .T_EXEC_LONG(TXL), .T_LOCK_TO(TLO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_rs(a_rs), .a_data(a_data), .a_lock(a_lock),
        .a_ready(a_ready), .a_done(a_done),
        .b_valid(b_valid), .b_rs(b_rs), .b_data(b_data), .b_lock(b_lock),
        .b_ready(b_ready), .b_done(b_done),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_en(lcd_en), .lcd_rw(lcd_rw),
        .lcd_on(lcd_on), .lcd_blon(lcd_blon), .busy(busy), .owner(owner), .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0, n_fail = 0;
    req_t qa[$], qb[$];
    bit   rnd_mode = 0, seen_ra = 0, seen_rb = 0;
    int   ra_log[$], rb_log[$], da_log[$], db_log[$], rise_log[$], fall_log[$], err_log[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int at_q(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.rs = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
            0: r.data = 8'h01;
            1: r.data = 8'h02;
            2: r.data = 8'h03;
            3: r.data = CMD_LINE2;
            default: r.data = 8'($urandom);
        endcase
        r.lock = ($urandom_range(0, 3) == 0);
        return r;
    endfunction

    // Requester driver: pops a byte after its ready, holds the rest stable.
    always @(posedge clk) begin
        #1;
        if (seen_ra && qa.size() > 0) qa.delete(0);
        if (seen_rb && qb.size() > 0) qb.delete(0);
        if (rnd_mode && qa.size() == 0 && $urandom_range(0, 3) == 0) qa.push_back(rand_req());
        if (rnd_mode && qb.size() == 0 && $urandom_range(0, 3) == 0) qb.push_back(rand_req());
        a_valid = qa.size() > 0 && !(rnd_mode && $urandom_range(0, 15) == 0);
        b_valid = qb.size() > 0 && !(rnd_mode && $urandom_range(0, 15) == 0);
        if (qa.size() > 0) begin a_rs = qa[0].rs; a_data = qa[0].data; a_lock = qa[0].lock; end
        if (qb.size() > 0) begin b_rs = qb[0].rs; b_data = qb[0].data; b_lock = qb[0].lock; end
    end

    // Reference model: a transfer granted in cycle g occupies the bus until g+TS+TE+tx.
    int         cyc, g, tx, wd;
    bit         who, m_rs, m_owner, m_last_b, m_lock, prev_en;
    logic [7:0] m_data;

    always @(negedge clk) begin
        bit idle, en_exp, fin, ea, eb, ga, gb, tick, err_exp;
        seen_ra = a_ready;
        seen_rb = b_ready;
        if (!reset_n) begin
            check("rst_en", lcd_en, 0);
            check("rst_rs", lcd_rs, 0);
            check("rst_data", lcd_data, 0);
            check("rst_ready", {a_ready, b_ready}, 0);
            check("rst_done", {a_done, b_done}, 0);
            check("rst_lock_err", lock_err, 0);
            check("rst_owner", owner, 0);
            check("rst_busy", busy, 1);
            cyc = 0; g = -1; tx = 0; wd = 0; who = 0;
            m_rs = 0; m_data = 0; m_owner = 0; m_last_b = 1; m_lock = 0; prev_en = 0;
        end else begin
            idle   = cyc >= TP && (g < 0 || cyc > g + TS + TE + tx);
            en_exp = g >= 0 && cyc >= g + 1 + TS && cyc < g + 1 + TS + TE;
            fin    = g >= 0 && cyc == g + TS + TE + tx;
            ea     = a_valid && (!m_lock || !m_owner);
            eb     = b_valid && (!m_lock || m_owner);
            ga     = idle && ea && (!eb || m_last_b);
            gb     = idle && eb && (!ea || !m_last_b);
            tick   = idle && m_lock && !(m_owner ? b_valid : a_valid);
`ifdef LCD_ARB_WATCHDOG_EN
            err_exp = tick && wd == TLO - 1;
`else
            err_exp = 0;
`endif
            check("lcd_en", lcd_en, en_exp);
            check("busy", busy, !idle);
            check("a_ready", a_ready, ga);
            check("b_ready", b_ready, gb);
            check("a_done", a_done, fin && !who);
            check("b_done", b_done, fin && who);
            check("lcd_rs", lcd_rs, m_rs);
            check("lcd_data", lcd_data, m_data);
            check("owner", owner, m_owner);
            check("lock_err", lock_err, err_exp);
            check("lcd_pins_const", {lcd_rw, lcd_on, lcd_blon}, 3'b011);
            if (a_ready) ra_log.push_back(cyc);
            if (b_ready) rb_log.push_back(cyc);
            if (a_done)  da_log.push_back(cyc);
            if (b_done)  db_log.push_back(cyc);
            if (lock_err) err_log.push_back(cyc);
            if (lcd_en && !prev_en) rise_log.push_back(cyc);
            if (!lcd_en && prev_en) fall_log.push_back(cyc);
            prev_en = lcd_en;
            if (ga || gb) begin
                g = cyc; who = gb; m_owner = gb; m_last_b = gb;
                m_rs   = gb ? b_rs : a_rs;
                m_data = gb ? b_data : a_data;
                m_lock = gb ? b_lock : a_lock;
                tx = (!m_rs && m_data >= 8'h01 && m_data <= 8'h03) ? TXL : TXS;
                wd = 0;
            end else if (err_exp) begin
                m_lock = 0; wd = 0;
            end else if (tick) begin
                wd++;
            end
            cyc++;
        end
    end

    task automatic clear_logs();
        ra_log.delete(); rb_log.delete(); da_log.delete(); db_log.delete();
        rise_log.delete(); fall_log.delete(); err_log.delete();
    endtask

    task automatic start_phase();
        @(posedge clk); #1;
        reset_n = 0;
        qa.delete(); qb.delete();
        clear_logs();
        repeat (2) @(posedge clk);
    endtask

    task automatic release_rst();
        @(posedge clk); #1;
        reset_n = 1;
    endtask

    task automatic push_a(input logic rs, input logic [7:0] d, input logic lk);
        req_t r; r.rs = rs; r.data = d; r.lock = lk; qa.push_back(r);
    endtask

    task automatic push_b(input logic rs, input logic [7:0] d, input logic lk);
        req_t r; r.rs = rs; r.data = d; r.lock = lk; qb.push_back(r);
    endtask

    initial begin
        // Single data byte: power-on, setup, enable and exec timing.
        start_phase();
        push_a(1, 8'h41, 0);
        release_rst();
        repeat (40) @(posedge clk);
        check("p1_ready_cycle", at_q(ra_log, 0), 10);
        check("p1_en_rise", at_q(rise_log, 0), 13);
        check("p1_en_fall", at_q(fall_log, 0), 16);
        check("p1_done_cycle", at_q(da_log, 0), 19);
        check("p1_done_count", da_log.size(), 1);

        // Clear command takes the long exec wait, the next data byte the short one.
        start_phase();
        push_a(0, CMD_CLEAR, 0);
        push_a(1, 8'h41, 0);
        release_rst();
        repeat (45) @(posedge clk);
        check("p2_ready0", at_q(ra_log, 0), 10);
        check("p2_done0", at_q(da_log, 0), 23);
        check("p2_ready1", at_q(ra_log, 1), 24);
        check("p2_done1", at_q(da_log, 1), 33);

        // Both valid, no lock: strict alternation every 10 cycles.
        start_phase();
        for (int i = 0; i < 4; i++) begin
            push_a(1, 8'(8'h30 + i), 0);
            push_b(1, 8'(8'h60 + i), 0);
        end
        release_rst();
        repeat (70) @(posedge clk);
        check("p3_a0", at_q(ra_log, 0), 10);
        check("p3_b0", at_q(rb_log, 0), 20);
        check("p3_a1", at_q(ra_log, 1), 30);
        check("p3_b1", at_q(rb_log, 1), 40);
        check("p3_a2", at_q(ra_log, 2), 50);

        // A holds the lock across two bytes; B waits until A releases it.
        start_phase();
        push_a(0, CMD_LINE2, 1);
        push_a(1, 8'h31, 1);
        push_a(1, 8'h32, 0);
        push_b(1, 8'h55, 0);
        release_rst();
        repeat (60) @(posedge clk);
        check("p4_a1", at_q(ra_log, 1), 20);
        check("p4_a2", at_q(ra_log, 2), 30);
        check("p4_b0", at_q(rb_log, 0), 40);

        // Reset during the enable pulse drops lcd_en at once and loses the byte.
        start_phase();
        push_a(1, 8'h41, 0);
        release_rst();
        for (int i = 0; i < 40 && rise_log.size() == 0; i++) @(posedge clk);
        check("p5_en_seen", rise_log.size(), 1);
        #1 reset_n = 0;
        #1 check("p5_en_drop", lcd_en, 0);
        check("p5_no_done", da_log.size(), 0);
        repeat (2) @(posedge clk);
        clear_logs();
        push_a(1, 8'h42, 0);
        release_rst();
        repeat (30) @(posedge clk);
        check("p5_ready_after_rst", at_q(ra_log, 0), 10);
        check("p5_done_after_rst", at_q(da_log, 0), 19);

        // A locks then goes silent while B waits.
        start_phase();
        push_a(1, 8'h41, 1);
        push_b(1, 8'h55, 0);
        release_rst();
        repeat (60) @(posedge clk);
        check("p6_a0", at_q(ra_log, 0), 10);
`ifdef LCD_ARB_WATCHDOG_EN
        check("p6_err_cycle", at_q(err_log, 0), 39);
        check("p6_err_count", err_log.size(), 1);
        check("p6_b_after_wd", at_q(rb_log, 0), 40);
`else
        check("p6_no_err", err_log.size(), 0);
        check("p6_b_starved", rb_log.size(), 0);
`endif

        // Random traffic with locks, long commands and withdrawn requests.
        start_phase();
        rnd_mode = 1;
        release_rst();
        repeat (3000) @(posedge clk);
        rnd_mode = 0;
        check("rnd_activity", (ra_log.size() + rb_log.size()) > 20, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
